muldiv_seq: RTL and testbench

Multi-cycle sequencer that owns the HI/LO register pair and executes MULT, MULTU, DIV and DIVU iteratively on behalf of the ALU. It sits beside the ALU in the execute stage. The ALU stays purely combinational; this block accepts an operation, runs 32 shift-add or restoring-divide iterations, and commits a 64-bit result to HI/LO. It also raises a stall to the pipeline when MFHI/MFLO arrives while an operation is still in flight.

---
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_seq.sv | 137 +++++++++++++
 tb/tb_muldiv_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake and register-access bundle between the
// execute stage and the multiply/divide sequencer.
interface muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic             rd_req;
   logic             busy;
   logic             done;
   logic             stall;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, op1, op2, mthi, mtlo, wdata, rd_req,
      input  busy, done, stall, hi, lo
   );

   modport slave (
      input  start, op, op1, op2, mthi, mtlo, wdata, rd_req,
      output busy, done, stall, hi, lo
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// 32 shift-add / restoring-divide steps, then sign fix.
module muldiv_seq (
   input  logic        clk,
   input  logic        rst_n,
   muldiv_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [5:0]  cnt_q;
   logic [63:0] acc_q;
   logic [31:0] rem_q;
   logic [31:0] div_q;
   logic        is_div_q;
   logic        neg_q_q;
   logic        neg_r_q;
   logic        dz_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        done_q;

   logic        mtx;
   logic        busy;
   logic        accept;
   logic        sgn;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] sum;
   logic [32:0] sh;
   logic [32:0] diff;
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rmd;

   assign mtx    = bus.mthi | bus.mtlo;
   assign busy   = (state_q != IDLE);
   assign accept = (state_q == IDLE) & bus.start;

   assign bus.busy  = busy;
   assign bus.done  = done_q;
   assign bus.stall = bus.rd_req & busy;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

   // operand magnitudes and per-step arithmetic
   always_comb begin
      sgn   = ~bus.op[0];
      a_neg = sgn & bus.op1[31];
      b_neg = sgn & bus.op2[31];
      a_mag = a_neg ? -bus.op1 : bus.op1;
      b_mag = b_neg ? -bus.op2 : bus.op2;
      sum   = {1'b0, acc_q[63:32]}
            + (acc_q[0] ? {1'b0, div_q} : 33'd0);
      sh    = {rem_q, acc_q[31]};
      diff  = sh - {1'b0, div_q};
      prod  = neg_q_q ? -acc_q : acc_q;
      quo   = neg_q_q ? -acc_q[31:0] : acc_q[31:0];
      rmd   = neg_r_q ? -rem_q : rem_q;
   end

   // next state; an MTHI/MTLO while busy aborts to IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.start) state_d = RUN;
         RUN: begin
            if (mtx)
               state_d = IDLE;
            else if (cnt_q == 6'd1)
               state_d = FIX;
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // datapath, iteration and HI/LO commit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= 6'd0;
         acc_q    <= 64'd0;
         rem_q    <= 32'd0;
         div_q    <= 32'd0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == FIX) & ~mtx;
         if (accept) begin
            cnt_q    <= 6'd32;
            acc_q    <= {32'd0, a_mag};
            rem_q    <= 32'd0;
            div_q    <= b_mag;
            is_div_q <= bus.op[1];
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            dz_q     <= (bus.op2 == 32'd0);
         end else if (state_q == RUN) begin
            cnt_q <= cnt_q - 6'd1;
            if (!is_div_q) begin
               acc_q <= {sum, acc_q[31:1]};
            end else if (!diff[32]) begin
               rem_q        <= diff[31:0];
               acc_q[31:0]  <= {acc_q[30:0], 1'b1};
            end else begin
               rem_q        <= sh[31:0];
               acc_q[31:0]  <= {acc_q[30:0], 1'b0};
            end
         end
         if (state_q == FIX && !mtx) begin
            if (!is_div_q) begin
               hi_q <= prod[63:32];
               lo_q <= prod[31:0];
            end else begin
               hi_q <= rmd;
               lo_q <= dz_q ? 32'hFFFF_FFFF : quo;
            end
         end
         if (bus.mthi) hi_q <= bus.wdata;
         if (bus.mtlo) lo_q <= bus.wdata;
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases
// plus random ops against an arithmetic reference.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   muldiv_seq_if bus ();

   muldiv_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [63:0] ref_model(
      input logic [1:0] o, input logic [31:0] a, b);
      longint sa, sb, q, m;
      logic [63:0] r;
      sa = $signed(a);
      sb = $signed(b);
      r = 64'd0;
      case (o)
         2'd0: r = 64'(sa * sb);
         2'd1: r = {32'd0, a} * {32'd0, b};
         2'd2: begin
            if (b == 32'd0)
               r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               r = {32'd0, 32'h8000_0000};
            else begin
               q = sa / sb;
               m = sa % sb;
               r = {m[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
            else            r = {a % b, a / b};
         end
      endcase
      return r;
   endfunction

   task automatic chk(input string tag,
                      input logic [63:0] obs, exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [1:0] o,
                        input logic [31:0] a, b,
                        input bit second, input bit mt);
      logic [63:0] exp;
      logic [31:0] hi0;
      int n, sc;
      exp = ref_model(o, a, b);
      hi0 = mt ? 32'h1111_2222 : bus.hi;
      bus.start  = 1'b1;
      bus.op     = o;
      bus.op1    = a;
      bus.op2    = b;
      bus.rd_req = 1'b1;
      if (mt) begin
         bus.mthi  = 1'b1;
         bus.wdata = 32'h1111_2222;
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.mthi  = 1'b0;
      n = 0;
      sc = 0;
      while (!bus.done && n < 40) begin
         if (bus.stall) sc++;
         if (n == 16) chk("hold_hi", bus.hi, hi0);
         if (second && n == 5) begin
            bus.start = 1'b1;
            bus.op    = ~o;
            bus.op1   = $urandom;
            bus.op2   = $urandom;
         end
         @(negedge clk);
         bus.start = 1'b0;
         n++;
      end
      chk("latency", n, 33);
      chk("stall_cycles", sc, 33);
      chk("stall_at_done", bus.stall, 0);
      chk("busy_at_done", bus.busy, 0);
      chk("hi", bus.hi, exp[63:32]);
      chk("lo", bus.lo, exp[31:0]);
      bus.rd_req = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", bus.done, 0);
   endtask

   initial begin
      int n, dn;
      logic [31:0] hi0, a, b;
      logic [1:0] o;
      bus.start  = 1'b0;
      bus.op     = 2'd0;
      bus.op1    = 32'd0;
      bus.op2    = 32'd0;
      bus.mthi   = 1'b0;
      bus.mtlo   = 1'b0;
      bus.wdata  = 32'd0;
      bus.rd_req = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_stall", bus.stall, 0);
      bus.rd_req = 1'b0;
      rst_n = 1'b1;

      bus.mthi  = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mthi = 1'b0;
      chk("mthi_idle", bus.hi, 32'hDEAD_BEEF);

      do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
      chk("multu_max_lo", bus.lo, 32'h0000_0001);
      do_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
      do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
      chk("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
      do_op(2'd3, 32'h1234_5678, 32'h0, 0, 0);
      do_op(2'd2, 32'hFFFF_FFF9, 32'h0, 0, 0);
      do_op(2'd3, 32'd100, 32'd7, 0, 0);
      chk("divu_100_7_hi", bus.hi, 32'd2);
      do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
      do_op(2'd3, 32'd12345, 32'd678, 1, 0);
      do_op(2'd0, 32'hFFFF_FF00, 32'd77, 0, 1);

      // MTLO at cycle 10 of RUN aborts
      hi0 = bus.hi;
      bus.start = 1'b1;
      bus.op    = 2'd1;
      bus.op1   = 32'h0BAD_F00D;
      bus.op2   = 32'h0000_1234;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.mtlo  = 1'b1;
      bus.wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      bus.mtlo = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_lo", bus.lo, 32'hA5A5_A5A5);
      chk("abort_hi", bus.hi, hi0);
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) dn++;
         @(negedge clk);
      end
      chk("abort_no_done", dn, 0);
      chk("abort_lo_kept", bus.lo, 32'hA5A5_A5A5);

      // reset at cycle 20 of RUN
      bus.start = 1'b1;
      bus.op    = 2'd2;
      bus.op1   = 32'h7777_0000;
      bus.op2   = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_hi", bus.hi, 0);
      chk("midrst_lo", bus.lo, 0);
      chk("midrst_busy", bus.busy, 0);
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) dn++;
         @(negedge clk);
      end
      chk("midrst_no_done", dn, 0);

      for (int i = 0; i < 30; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         n = $urandom_range(0, 7);
         case (n)
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'd1;
            3:       b = a;
            4:       b = 32'($urandom_range(1, 255));
            default: b = $urandom;
         endcase
         do_op(o, a, b, (i % 5) == 0, (i % 7) == 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
